sym_frame_sched: RTL and testbench
==================================

Name: sym_frame_sched

Overview:
- Symbol-rate frame scheduler for the transmit data source.
- Builds frames in three segments: a known alternating preamble, then a payload drawn from the maximal-length LFSR symbol generator, then a guard interval of constant symbols.
- Owns the LFSR clock enable, so the LFSR advances only while payload symbols are being consumed.
- Sits between the LFSR generator and the pulse-shaping/modulator input.

Parameters:
- PREAMBLE_LEN, 16, preamble symbols per frame (1..65535).
- PAYLOAD_LEN, 256, LFSR payload symbols per frame (1..65535).
- GUARD_LEN, 4, guard symbols per frame (1..65535).
- PRE_A, 4'h0, even-index preamble symbol.
- PRE_B, 4'hF, odd-index preamble symbol.
- GUARD_SYM, 4'h0, guard symbol value.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sym_clk_en  in  1  symbol-rate strobe, one clk wide.
- start  in  1  one-cycle pulse; begin a frame burst.
- stop  in  1  one-cycle pulse; end the burst after the current frame.
- n_frames  in  8  frames per burst, sampled at accepted start; 0 = continuous.
- lfsr_sym  in  4  current LFSR symbol.
- lfsr_cycle  in  1  LFSR full-period indication.
- lfsr_en  out  1  clock enable to the LFSR (combinational).
- sym_out  out  4  emitted symbol (registered).
- sym_valid  out  1  one-cycle pulse, sym_out updated.
- frame_start  out  1  pulse coincident with sym_valid of preamble symbol 0.
- payload_active  out  1  high with sym_valid when sym_out is a payload symbol.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when the burst ends.
- frame_count  out  16  completed frames since the last accepted start, wraps mod 2^16.
- lfsr_wrapped  out  1  sticky: lfsr_cycle seen during the burst.

Behaviour:
- Reset values: all registered outputs 0, state=IDLE, seg_cnt=0, stop_pend=0.
- States: IDLE, PREAMBLE, PAYLOAD, GUARD. seg_cnt is 16-bit and indexes the next symbol within the segment.
- IDLE:
  - start=1 → PREAMBLE on the next clk, regardless of sym_clk_en.
  - On that start: latch n_frames; clear seg_cnt, frame_count, lfsr_wrapped, stop_pend.
  - stop is ignored in IDLE.
- Symbol emission happens only on cycles with sym_clk_en=1 and state != IDLE.
  - sym_out/sym_valid are registered, so they appear 1 clk after the strobe.
  - seg_cnt increments on each emission.
  - On the last index (LEN-1), seg_cnt clears and the state advances.
- PREAMBLE: sym_out = PRE_A if seg_cnt even, else PRE_B. frame_start=1 with index 0.
- PAYLOAD:
  - lfsr_en = sym_clk_en & (state==PAYLOAD).
  - sym_out <= lfsr_sym sampled on the same strobe edge, i.e. the pre-advance value.
  - Exactly PAYLOAD_LEN lfsr_en pulses per frame; lfsr_en is 0 in all other states.
- GUARD: sym_out = GUARD_SYM, payload_active=0. On the last guard symbol, frame_count increments, then:
  - if stop_pend, or (n_frames!=0 and frame_count+1==n_frames): → IDLE, done=1 coincident with the last guard sym_valid;
  - else → PREAMBLE.
- stop while busy sets stop_pend. The current frame always completes fully; there is no truncation.
- start while busy is ignored; no effect on the count or the latched n_frames.
- start and stop in the same IDLE cycle: start accepted, stop ignored.
- stop on the same cycle as the final guard emission ends the burst there. The result is identical to the n_frames termination.
- lfsr_wrapped sets on any clk with lfsr_cycle=1 while busy. It holds until the next accepted start or reset.
- Between strobes sym_out holds its value, and sym_valid/frame_start/payload_active are 0.
- Asynchronous reset mid-frame: immediate return to the reset values. lfsr_en drops to 0 immediately.
- busy is registered. It goes low the clk after done.

Test Plan:
- Single-frame sequence:
  - Stimulus: PREAMBLE_LEN=4, PAYLOAD_LEN=8, GUARD_LEN=2, sym_clk_en every 4 clk, n_frames=1, start.
  - Required: 14 sym_valid pulses with values 0,F,0,F, 8 LFSR symbols in generator order, 0,0.
  - Required: 8 lfsr_en pulses; frame_start on the 1st symbol; done on the 14th; frame_count=1; busy=0 one clk later.
- Multi-frame burst:
  - Stimulus: n_frames=3, same parameters.
  - Required: 42 symbols, 3 frame_start pulses, 24 lfsr_en pulses; payload continues the LFSR sequence across frames (no repeats); frame_count=3 at done.
- Continuous mode with stop:
  - Stimulus: n_frames=0; pulse stop at payload symbol 3 of frame 2.
  - Required: frame 2 completes all 14 symbols; done after its last guard symbol; frame_count=2.
- Ignored controls:
  - Stimulus: start while busy; also stop alone in IDLE.
  - Required: no change to the symbol sequence or frame_count; no state change in IDLE.
- Reset mid-payload:
  - Stimulus: assert reset during payload symbol 5.
  - Required: same-cycle lfsr_en=0, busy=0, sym_out=0.
  - Required: after release and start, the frame restarts with preamble symbol PRE_A.
- LFSR wrap flag:
  - Stimulus: drive lfsr_cycle=1 for one clk during the burst.
  - Required: lfsr_wrapped=1 through done; cleared by the next accepted start.

Source files
------------

// File: rtl/sym_frame_sched_if.sv
// sym_frame_sched_if: control, LFSR and symbol-output signals of the frame scheduler
//   master: drives strobe/start/stop/n_frames/lfsr_sym/lfsr_cycle, observes scheduler outputs
//   slave : the scheduler side
interface sym_frame_sched_if;
  logic        sym_clk_en;
  logic        start;
  logic        stop;
  logic [7:0]  n_frames;
  logic [3:0]  lfsr_sym;
  logic        lfsr_cycle;
  logic        lfsr_en;
  logic [3:0]  sym_out;
  logic        sym_valid;
  logic        frame_start;
  logic        payload_active;
  logic        busy;
  logic        done;
  logic [15:0] frame_count;
  logic        lfsr_wrapped;
  modport master (
    output sym_clk_en, start, stop, n_frames, lfsr_sym, lfsr_cycle,
    input  lfsr_en, sym_out, sym_valid, frame_start, payload_active, busy, done, frame_count, lfsr_wrapped
  );
  modport slave (
    input  sym_clk_en, start, stop, n_frames, lfsr_sym, lfsr_cycle,
    output lfsr_en, sym_out, sym_valid, frame_start, payload_active, busy, done, frame_count, lfsr_wrapped
  );
endinterface

// File: rtl/sym_frame_sched.sv
// sym_frame_sched: symbol-rate frame builder (alternating preamble, LFSR payload, constant guard)
//   clk, reset : clock, asynchronous active-high reset
//   bus        : sym_frame_sched_if.slave (strobe, start/stop, n_frames, LFSR in, symbol/status out)
module sym_frame_sched #(
  parameter int         PREAMBLE_LEN = 16,
  parameter int         PAYLOAD_LEN  = 256,
  parameter int         GUARD_LEN    = 4,
  parameter logic [3:0] PRE_A        = 4'h0,
  parameter logic [3:0] PRE_B        = 4'hF,
  parameter logic [3:0] GUARD_SYM    = 4'h0
) (
  input logic clk,
  input logic reset,
  sym_frame_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, GUARD} state_t;
  state_t      state;
  logic [15:0] seg_cnt;
  logic [7:0]  n_lat;
  logic        stop_pend;
  logic [15:0] seg_last;
  logic [3:0]  sym_next;
  logic        last_frame;
  assign bus.lfsr_en = bus.sym_clk_en && state == PAYLOAD;
  always_comb begin
    seg_last = state == PREAMBLE ? 16'(PREAMBLE_LEN - 1) :
               state == PAYLOAD  ? 16'(PAYLOAD_LEN - 1) : 16'(GUARD_LEN - 1);
    sym_next = state == PREAMBLE ? (seg_cnt[0] ? PRE_B : PRE_A) :
               state == PAYLOAD  ? bus.lfsr_sym : GUARD_SYM;
    // a stop arriving on the final guard strobe still ends the burst here
    last_frame = stop_pend || bus.stop || (n_lat != 8'd0 && bus.frame_count + 16'd1 == {8'd0, n_lat});
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      seg_cnt            <= '0;
      n_lat              <= '0;
      stop_pend          <= 1'b0;
      bus.sym_out        <= '0;
      bus.sym_valid      <= 1'b0;
      bus.frame_start    <= 1'b0;
      bus.payload_active <= 1'b0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.frame_count    <= '0;
      bus.lfsr_wrapped   <= 1'b0;
    end else begin
      bus.sym_valid      <= 1'b0;
      bus.frame_start    <= 1'b0;
      bus.payload_active <= 1'b0;
      bus.done           <= 1'b0;
      // registered from the current state so busy falls one clk after done
      bus.busy           <= state != IDLE;
      if (state == IDLE) begin
        if (bus.start) begin
          state            <= PREAMBLE;
          n_lat            <= bus.n_frames;
          seg_cnt          <= '0;
          stop_pend        <= 1'b0;
          bus.frame_count  <= '0;
          bus.lfsr_wrapped <= 1'b0;
        end
      end else begin
        if (bus.stop) stop_pend <= 1'b1;
        if (bus.lfsr_cycle) bus.lfsr_wrapped <= 1'b1;
        if (bus.sym_clk_en) begin
          bus.sym_valid      <= 1'b1;
          bus.sym_out        <= sym_next;
          bus.frame_start    <= state == PREAMBLE && seg_cnt == 16'd0;
          bus.payload_active <= state == PAYLOAD;
          seg_cnt            <= seg_cnt == seg_last ? 16'd0 : seg_cnt + 16'd1;
          if (seg_cnt == seg_last) begin
            if (state == PREAMBLE) state <= PAYLOAD;
            else if (state == PAYLOAD) state <= GUARD;
            else begin
              bus.frame_count <= bus.frame_count + 16'd1;
              state           <= last_frame ? IDLE : PREAMBLE;
              bus.done        <= last_frame;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_sym_frame_sched.sv
// tb_sym_frame_sched: scoreboard bench for sym_frame_sched with a 4-symbol/8-symbol/2-symbol frame
module tb_sym_frame_sched;
  logic clk = 1'b0;
  logic reset = 1'b1;
  sym_frame_sched_if bus ();
  sym_frame_sched #(.PREAMBLE_LEN(4), .PAYLOAD_LEN(8), .GUARD_LEN(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {logic [3:0] sym; logic fs; logic pa; logic dn;} exp_t;
  exp_t q[$];
  int n_checks = 0;
  int n_fail = 0;
  int sym_seen = 0;
  int en_cnt = 0;
  int exp_ptr = 0;
  int gen_ptr = 0;
  // x^4+x^3+1 sequence from seed 1, worked out by hand
  logic [3:0] tab [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
  assign bus.lfsr_sym = tab[gen_ptr];
  always @(posedge clk) if (bus.lfsr_en) gen_ptr <= (gen_ptr + 1) % 15;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.sym_valid) begin
        sym_seen++;
        if (q.size() == 0) check("unexpected_sym", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          check("sym_out", {28'd0, bus.sym_out}, {28'd0, e.sym});
          check("frame_start", {31'd0, bus.frame_start}, {31'd0, e.fs});
          check("payload_active", {31'd0, bus.payload_active}, {31'd0, e.pa});
          check("done", {31'd0, bus.done}, {31'd0, e.dn});
        end
      end else check("pulses_between_strobes", {29'd0, bus.frame_start, bus.payload_active, bus.done}, 0);
      if (bus.lfsr_en) en_cnt++;
    end
  end
  initial begin
    int div = 0;
    bus.sym_clk_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      div = (div + 1) % 4;
      bus.sym_clk_en = div == 0;
    end
  end
  task automatic push_frame(input logic last);
    for (int i = 0; i < 4; i++) q.push_back('{(i % 2) ? 4'hF : 4'h0, i == 0, 1'b0, 1'b0});
    for (int i = 0; i < 8; i++) begin
      q.push_back('{tab[exp_ptr], 1'b0, 1'b1, 1'b0});
      exp_ptr = (exp_ptr + 1) % 15;
    end
    for (int i = 0; i < 2; i++) q.push_back('{4'h0, 1'b0, 1'b0, last && i == 1});
  endtask
  task automatic pulse_start(input logic [7:0] n);
    @(posedge clk);
    #1 bus.n_frames = n;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask
  task automatic pulse_stop();
    @(posedge clk);
    #1 bus.stop = 1'b1;
    @(posedge clk);
    #1 bus.stop = 1'b0;
  endtask
  task automatic wait_syms(input int n);
    int t = 0;
    while (sym_seen < n && t < 400) begin
      @(posedge clk);
      t++;
    end
    if (sym_seen < n) check("wait_syms_timeout", sym_seen, n);
  endtask
  task automatic wait_done(input int fc, input logic wrapped, input int en_exp, input int en_base);
    int t = 0;
    @(negedge clk);
    while (!bus.done && t < 600) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", {31'd0, bus.done}, 1);
    check("frame_count", {16'd0, bus.frame_count}, fc);
    check("lfsr_wrapped", {31'd0, bus.lfsr_wrapped}, {31'd0, wrapped});
    check("busy_at_done", {31'd0, bus.busy}, 1);
    @(negedge clk);
    check("busy_after_done", {31'd0, bus.busy}, 0);
    check("lfsr_en_pulses", en_cnt - en_base, en_exp);
    check("queue_drained", q.size(), 0);
  endtask
  initial begin
    int base;
    int fbase;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.n_frames = 8'd0;
    bus.lfsr_cycle = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sym_out", {28'd0, bus.sym_out}, 0);
    check("rst_flags", {26'd0, bus.sym_valid, bus.busy, bus.done, bus.lfsr_wrapped, bus.lfsr_en, bus.frame_start}, 0);
    check("rst_frame_count", {16'd0, bus.frame_count}, 0);
    reset = 1'b0;
    // single frame
    base = en_cnt;
    push_frame(1'b1);
    pulse_start(8'd1);
    wait_done(1, 1'b0, 8, base);
    // three-frame burst with an LFSR period mark in the middle
    base = en_cnt;
    sym_seen = 0;
    push_frame(1'b0);
    push_frame(1'b0);
    push_frame(1'b1);
    pulse_start(8'd3);
    wait_syms(10);
    @(posedge clk);
    #1 bus.lfsr_cycle = 1'b1;
    @(posedge clk);
    #1 bus.lfsr_cycle = 1'b0;
    wait_done(3, 1'b1, 24, base);
    // continuous mode ended by stop during frame 2 payload
    base = en_cnt;
    sym_seen = 0;
    push_frame(1'b0);
    push_frame(1'b1);
    pulse_start(8'd0);
    check("wrapped_cleared_on_start", {31'd0, bus.lfsr_wrapped}, 0);
    check("count_cleared_on_start", {16'd0, bus.frame_count}, 0);
    wait_syms(21);
    pulse_stop();
    wait_done(2, 1'b0, 16, base);
    // start while busy is ignored, stop alone in IDLE is ignored
    base = en_cnt;
    sym_seen = 0;
    push_frame(1'b0);
    push_frame(1'b1);
    pulse_start(8'd2);
    wait_syms(5);
    pulse_start(8'd5);
    wait_done(2, 1'b0, 16, base);
    pulse_stop();
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("idle_stop_busy", {31'd0, bus.busy}, 0);
    check("idle_stop_count", {16'd0, bus.frame_count}, 2);
    // reset on the strobe of payload symbol 5
    sym_seen = 0;
    fbase = exp_ptr;
    push_frame(1'b1);
    pulse_start(8'd1);
    wait_syms(9);
    @(negedge clk);
    for (int t = 0; t < 8 && !bus.sym_clk_en; t++) @(negedge clk);
    check("lfsr_en_before_reset", {31'd0, bus.lfsr_en}, 1);
    #1 reset = 1'b1;
    #1;
    check("reset_lfsr_en", {31'd0, bus.lfsr_en}, 0);
    check("reset_busy", {31'd0, bus.busy}, 0);
    check("reset_sym_out", {28'd0, bus.sym_out}, 0);
    q.delete();
    exp_ptr = (fbase + 5) % 15;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    base = en_cnt;
    push_frame(1'b1);
    pulse_start(8'd1);
    wait_done(1, 1'b0, 8, base);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
